// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample pacer: FSM encoding, counter width and
// accumulator sizing helper.
package audio_pkg;

  localparam int unsigned UNDERRUN_CNT_W = 16;

  typedef logic [1:0] pacer_state_t;

  localparam pacer_state_t ST_IDLE  = 2'd0;
  localparam pacer_state_t ST_PRIME = 2'd1;
  localparam pacer_state_t ST_RUN   = 2'd2;

  // acc never exceeds CLK_HZ + RATE_HZ - 1 before the wrap is applied
  function automatic int unsigned acc_width(input int unsigned clk_hz,
                                            input int unsigned rate_hz);
    return $clog2(clk_hz + rate_hz);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush empties it in one cycle and wins over
// push/pop.
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 48
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces buffered stereo samples out at RATE_HZ using a fractional accumulator and drives a
// registered audio clock suitable for a BUFG.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 30_000_000,
  parameter int unsigned RATE_HZ       = 48000,
  parameter int unsigned WIDTH         = 24,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PRIME_LEVEL   = 2,
  parameter int unsigned UNDERRUN_ZERO = 0
) (
  input  logic                      clk30,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_left,
  input  logic [WIDTH-1:0]          in_right,
  output logic [WIDTH-1:0]          audioL,
  output logic [WIDTH-1:0]          audioR,
  output logic                      sample_tick,
  output logic                      audio_clk,
  output logic                      running,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam int unsigned ACC_W = acc_width(CLK_HZ, RATE_HZ);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  localparam logic [ACC_W-1:0] RATE_V = ACC_W'(RATE_HZ);
  localparam logic [ACC_W-1:0] CLK_V  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] HALF_V = ACC_W'(CLK_HZ / 2);

  pacer_state_t              r_state;
  pacer_state_t              w_state_d;
  logic [ACC_W-1:0]          r_acc;
  logic [ACC_W-1:0]          w_acc_next;
  logic [ACC_W-1:0]          w_acc_wrap;
  logic [ACC_W-1:0]          w_acc_d;
  logic                      w_run_active;
  logic                      w_tick;
  logic                      w_aclk_d;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_flush;
  logic                      w_full;
  logic                      w_empty;
  logic [LVL_W-1:0]          w_level;
  logic [LVL_W-1:0]          w_level_d;
  logic                      w_rdy_d;
  logic [2*WIDTH-1:0]        w_head;
  logic                      r_in_ready;
  logic                      r_tick;
  logic                      r_aclk;
  logic [WIDTH-1:0]          r_left;
  logic [WIDTH-1:0]          r_right;
  logic [UNDERRUN_CNT_W-1:0] r_ucnt;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_d = ST_PRIME;
      ST_PRIME: begin
        if (!enable)                               w_state_d = ST_IDLE;
        else if (w_level >= LVL_W'(PRIME_LEVEL))   w_state_d = ST_RUN;
      end
      ST_RUN:   if (!enable) w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  // A dropping enable suppresses the tick on the same edge it takes effect.
  always_comb begin
    w_run_active = (r_state == ST_RUN) && enable;
    w_acc_next   = r_acc + RATE_V;
    w_tick       = w_run_active && (w_acc_next >= CLK_V);
    w_acc_wrap   = w_tick ? (w_acc_next - CLK_V) : w_acc_next;
    w_acc_d      = w_run_active ? w_acc_wrap : '0;
    w_aclk_d     = w_run_active && (w_acc_wrap < HALF_V);
  end

  always_comb begin
    w_flush   = (w_state_d == ST_IDLE);
    w_push    = in_valid && r_in_ready && !w_full;
    w_pop     = w_tick && !w_empty;
    w_level_d = w_flush ? '0 : (w_level + LVL_W'(w_push) - LVL_W'(w_pop));
    w_rdy_d   = (w_state_d != ST_IDLE) && (w_level_d != LVL_W'(DEPTH));
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_fifo (
    .i_clk   (clk30),
    .i_rst   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_left, in_right}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
      r_tick     <= 1'b0;
      r_aclk     <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_ucnt     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_acc      <= w_acc_d;
      r_in_ready <= w_rdy_d;
      r_tick     <= w_tick;
      r_aclk     <= w_aclk_d;
      if (w_state_d == ST_IDLE) begin
        r_left  <= '0;
        r_right <= '0;
      end else if (w_pop) begin
        {r_left, r_right} <= w_head;
      end else if (w_tick && (UNDERRUN_ZERO != 0)) begin
        r_left  <= '0;
        r_right <= '0;
      end
      if (w_tick && w_empty && (r_ucnt != '1)) r_ucnt <= r_ucnt + 1'b1;
    end
  end

  assign in_ready       = r_in_ready;
  assign audioL         = r_left;
  assign audioR         = r_right;
  assign sample_tick    = r_tick;
  assign audio_clk      = r_aclk;
  assign running        = (r_state == ST_RUN);
  assign underrun_count = r_ucnt;

endmodule

// File: doc/audio_sample_pacer.md
# audio_sample_pacer

- Sits in the `clk30` domain between the audio waveform generator and the HDMI transmitter's audio input.
- Accepts stereo samples through a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per audio period, with the period set by a fractional rate accumulator.
- Drives a registered, glitch-free audio clock intended for the BUFG that feeds the transmitter's `clk_audio`; it replaces the gated, combinational audio clock currently used.

## Interface
Parameters:
- `CLK_HZ`, 30_000_000: frequency of `clk30`.
- `RATE_HZ`, 48000: audio sample rate; must satisfy 0 < `RATE_HZ` < `CLK_HZ`/2.
- `WIDTH`, 24: bits per channel.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `PRIME_LEVEL`, 2: FIFO occupancy required before playback starts; 1 ≤ `PRIME_LEVEL` ≤ `DEPTH`.
- `UNDERRUN_ZERO`, 0: on underrun, 1 outputs zeros; 0 holds the last sample.

Ports:
- `clk30`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run request.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: high when the FIFO is not full and state ≠ IDLE.
- `in_left`, in, `WIDTH`: left channel input.
- `in_right`, in, `WIDTH`: right channel input.
- `audioL`, out, `WIDTH`: current left sample, registered.
- `audioR`, out, `WIDTH`: current right sample, registered.
- `sample_tick`, out, 1: one-cycle pulse; high on the same cycle `audioL`/`audioR` update.
- `audio_clk`, out, 1: registered square wave at `RATE_HZ`; rises together with `sample_tick`.
- `running`, out, 1: high in state RUN.
- `underrun_count`, out, 16: number of underruns; saturates at 0xFFFF.

## Operation
The FSM has three states: IDLE, PRIME and RUN.

- **IDLE**
  - The FIFO is flushed and `acc` = 0.
  - `audioL`/`audioR` = 0, `audio_clk` = 0, `in_ready` = 0.
  - `enable`=1 moves to PRIME.
- **PRIME**
  - Pushes are accepted; no ticks are generated.
  - Moves to RUN on the cycle after occupancy ≥ `PRIME_LEVEL`.
  - `enable`=0 returns to IDLE.
- **RUN**
  - Every cycle: `acc_next` = `acc` + `RATE_HZ`.
  - If `acc_next` ≥ `CLK_HZ`: tick, and `acc` ← `acc_next` − `CLK_HZ`.
  - `acc` is ceil(log2(`CLK_HZ`+`RATE_HZ`)) bits wide; this is 25 bits at the defaults.
  - On a tick:
    - If the FIFO is non-empty, pop its head into `audioL`/`audioR`.
    - If it is empty, this is an underrun: increment `underrun_count` with saturation and apply the `UNDERRUN_ZERO` policy.
    - The FSM remains in RUN after an underrun.
  - `audio_clk` ← (`acc_next` after wrap) < `CLK_HZ`/2, evaluated only in RUN; it is 0 in every other state.
  - `enable`=0 moves to IDLE on the next edge, flushing the FIFO and zeroing the outputs.
- **Handshake:** a push occurs when `in_valid` && `in_ready` at the edge. Data must be held until accepted. There is no input-to-output bypass.
- **Reset:** `reset` forces IDLE and all outputs to 0, including `underrun_count`. Only reset clears `underrun_count`; disabling via `enable` does not.

## Timing
- **Reset values:**
  - Outputs: `in_ready`=0, `audioL`=`audioR`=0, `sample_tick`=0, `audio_clk`=0, `running`=0, `underrun_count`=0.
  - Internal: FIFO empty, `acc`=0.
- **Entering RUN:** `acc`=0. The first `sample_tick` occurs ceil(`CLK_HZ`/`RATE_HZ`) cycles later, i.e. 625 cycles at the defaults. At the defaults ticks are exactly 625 cycles apart.
- **Fractional rates:** intervals alternate between floor and ceil of `CLK_HZ`/`RATE_HZ`. Long-run error is 0.
- **`in_ready` timing:** registered view of FIFO state, so it deasserts the cycle after the FIFO becomes full. It reasserts the cycle after a pop from full. A pop and a push in the same cycle are legal and leave occupancy unchanged.
- **Empty FIFO, push and tick in the same cycle:** this counts as an underrun, and the pushed sample is stored for the next tick.
- **`enable` drop coinciding with a tick:** the tick is suppressed, and IDLE takes effect on that edge.
- **FSM latency:** IDLE→PRIME takes 1 cycle after `enable`. PRIME→RUN takes 1 cycle after the occupancy condition is met.

## Structure
- **Shared package (`audio_pkg`):**
  - FSM state encoding (IDLE/PRIME/RUN).
  - `UNDERRUN_CNT_W` = 16.
  - A helper function for the accumulator width, `clog2`(`CLK_HZ`+`RATE_HZ`).
- **Sub-module `sample_fifo`:**
  - Synchronous single-clock FIFO of `DEPTH` entries × 2·`WIDTH` bits.
  - Read/write pointers carry one extra wrap bit.
  - Provides full, empty, level and flush.
- **Top-level FSM, accumulator and output registers** live in `audio_sample_pacer`.
- **Integration:** the top level drives `audio_clk` into the BUFG that feeds `clk_audio`. Nothing derived from combinational logic may reach the BUFG.

## Test plan
- **Default rate:** defaults, `enable`=1, source always valid with incrementing samples → RUN entered after 2 pushes + 1 cycle; first tick 625 cycles later; ticks exactly 625 apart; `audioL` sequence 0,1,2,… with no gaps; `underrun_count`=0.
- **Fractional rate:** `CLK_HZ`=100, `RATE_HZ`=30 → tick intervals repeat 4,3,3; `audio_clk` rises on every tick.
- **Underrun:** stop the source after 3 samples → at the 4th tick `underrun_count`=1 and `audioL` holds the 3rd sample. Repeat with `UNDERRUN_ZERO`=1 → output 0.
- **Backpressure:** `DEPTH`=4, source valid, no ticks (state PRIME with `PRIME_LEVEL`=4) → exactly 4 pushes, then `in_ready`=0; data held at the input is accepted only after a pop.
- **Disable mid-playback:** drop `enable` mid-RUN on a tick cycle → no `sample_tick`; next edge IDLE, outputs 0, FIFO empty; `underrun_count` retained.
- **Reset mid-operation:** assert `reset` asynchronously mid-RUN → all outputs 0 immediately; restart from IDLE reproduces the default-rate scenario timing.
